// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: filtered x1 quadrature decoder with modulo-STEPS position,
// home switch, sticky illegal-transition flag and CPU read snapshot.
module rotary_quad_decoder #(
   parameter int STEPS = 12,
   parameter int FILT  = 3
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       CE,
   input  logic       QA,
   input  logic       QB,
   input  logic       nCENTER,
   input  logic       RD,
   output logic [3:0] POS,
   output logic       DU,
   output logic       STEP,
   output logic       WRAP,
   output logic [5:0] RDATA,
   output logic       ERR
);
   localparam logic [3:0] TOP = 4'(STEPS - 1);
   localparam logic [3:0] LIM = 4'(FILT);
   logic       r_qa_s1, r_qa_s2, r_qb_s1, r_qb_s2, r_nc_s1, r_nc_s2;
   logic [1:0] r_cand, r_f;
   logic [3:0] r_cnt, r_pos;
   logic       r_du, r_step, r_wrap, r_err;
   logic [5:0] r_rdata;
   logic [1:0] w_ab;
   logic [3:0] w_cnt_nx;
   logic       w_acc, w_up, w_dn, w_ill, w_center, w_top, w_bot;
   always_comb begin
      w_ab     = {r_qa_s2, r_qb_s2};
      // a sample that differs from the one counted last CE cycle restarts the count at itself
      w_cnt_nx = (w_ab != r_cand) ? 4'd1 : r_cnt + 4'd1;
      w_acc    = CE && (w_ab != r_f) && (w_cnt_nx == LIM);
      w_up     = w_acc && (r_f == 2'b10) && (w_ab == 2'b00);
      w_dn     = w_acc && (r_f == 2'b01) && (w_ab == 2'b00);
      w_ill    = w_acc && ((r_f ^ w_ab) == 2'b11);
      w_center = ~r_nc_s2;
      w_top    = (r_pos == TOP);
      w_bot    = (r_pos == 4'd0);
   end
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         {r_qa_s1, r_qa_s2, r_qb_s1, r_qb_s2, r_nc_s1, r_nc_s2} <= '0;
         r_cand <= '0;
         r_f    <= '0;
         r_cnt  <= '0;
      end else begin
         {r_qa_s1, r_qa_s2} <= {QA, r_qa_s1};
         {r_qb_s1, r_qb_s2} <= {QB, r_qb_s1};
         {r_nc_s1, r_nc_s2} <= {nCENTER, r_nc_s1};
         if (CE) begin
            r_cand <= w_ab;
            r_cnt  <= (w_ab == r_f || w_acc) ? 4'd0 : w_cnt_nx;
            r_f    <= w_acc ? w_ab : r_f;
         end
      end
   end
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_pos   <= '0;
         r_du    <= 1'b0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_err <= w_ill | (r_err & ~RD);
         if (RD) r_rdata <= {r_err, r_du, r_pos};
         if (w_center) begin
            r_pos  <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
         end else begin
            r_step <= w_up | w_dn;
            r_wrap <= (w_up && w_top) || (w_dn && w_bot);
            if (w_up) r_pos <= w_top ? 4'd0 : r_pos + 4'd1;
            else if (w_dn) r_pos <= w_bot ? TOP : r_pos - 4'd1;
            if (w_up || w_dn) r_du <= w_dn;
         end
      end
   end
   assign POS   = r_pos;
   assign DU    = r_du;
   assign STEP  = r_step;
   assign WRAP  = r_wrap;
   assign RDATA = r_rdata;
   assign ERR   = r_err;
endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb_rotary_quad_decoder: directed scoreboard bench for rotary_quad_decoder (STEPS=12, FILT=3).
module tb_rotary_quad_decoder;
   logic       CLK = 1'b0, nRESET = 1'b0, CE = 1'b1, QA = 1'b0, QB = 1'b0, nCENTER = 1'b1, RD = 1'b0;
   logic [3:0] POS;
   logic       DU, STEP, WRAP, ERR;
   logic [5:0] RDATA;
   int         errors = 0, checks = 0, step_cnt = 0, wrap_cnt = 0, s0, w0;
   typedef struct {string tag; logic [7:0] exp;} exp_t;
   exp_t       sb[$];
   rotary_quad_decoder #(.STEPS(12), .FILT(3)) dut (
      .CLK(CLK), .nRESET(nRESET), .CE(CE), .QA(QA), .QB(QB), .nCENTER(nCENTER), .RD(RD),
      .POS(POS), .DU(DU), .STEP(STEP), .WRAP(WRAP), .RDATA(RDATA), .ERR(ERR)
   );
   always #5 CLK = ~CLK;
   always @(negedge CLK) begin
      if (nRESET && STEP) step_cnt++;
      if (nRESET && WRAP) wrap_cnt++;
   end
   task automatic push(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask
   task automatic pop_chk(input logic [7:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask
   task automatic hold(input logic [1:0] ab, input int n);
      {QA, QB} = ab;
      repeat (n) @(posedge CLK);
      #1;
   endtask
   task automatic up_cyc();
      hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
   endtask
   task automatic dn_cyc();
      hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
   endtask
   task automatic rd_pulse();
      RD = 1'b1;
      @(posedge CLK);
      #1;
      RD = 1'b0;
   endtask
   initial begin
      push("rst_pos", 0); push("rst_du", 0); push("rst_step", 0);
      push("rst_wrap", 0); push("rst_err", 0); push("rst_rdata", 0);
      #3;
      pop_chk(POS); pop_chk(DU); pop_chk(STEP); pop_chk(WRAP); pop_chk(ERR); pop_chk(RDATA);
      @(negedge CLK) nRESET = 1'b1;
      @(posedge CLK);
      #1;
      // one up cycle with exact input-to-position latency on the final phase
      hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
      push("lat4_pos", 0); push("lat5_pos", 1); push("lat5_step", 1); push("lat5_du", 0);
      push("lat6_step", 0); push("up1_steps", 1); push("up1_wraps", 0);
      hold(2'b00, 4);
      pop_chk(POS);
      hold(2'b00, 1);
      pop_chk(POS); pop_chk(STEP); pop_chk(DU);
      hold(2'b00, 1);
      pop_chk(STEP);
      hold(2'b00, 2);
      pop_chk(8'(step_cnt)); pop_chk(8'(wrap_cnt));
      // down through zero wraps to STEPS-1
      push("dn1_pos", 0); push("dn1_du", 1); push("dn2_pos", 11); push("dn2_du", 1); push("dn2_wraps", 1);
      dn_cyc();
      pop_chk(POS); pop_chk(DU);
      dn_cyc();
      pop_chk(POS); pop_chk(DU); pop_chk(8'(wrap_cnt));
      push("up_top_pos", 0); push("up_top_wraps", 2);
      up_cyc();
      pop_chk(POS); pop_chk(8'(wrap_cnt));
      push("up11_pos", 11); push("up11_wraps", 2); push("up12_pos", 0); push("up12_wraps", 3);
      for (int i = 0; i < 11; i++) up_cyc();
      pop_chk(POS); pop_chk(8'(wrap_cnt));
      up_cyc();
      pop_chk(POS); pop_chk(8'(wrap_cnt));
      // short glitch on QA is rejected
      s0 = step_cnt;
      push("glitch_pos", 0); push("glitch_steps", 0); push("glitch_err", 0);
      hold(2'b10, 2); hold(2'b00, 10);
      pop_chk(POS); pop_chk(8'(step_cnt - s0)); pop_chk(ERR);
      // illegal jump, read-clear, then illegal jump coincident with read
      push("ill_err", 1); push("ill_pos", 0); push("rd_rdata", 8'h20); push("rd_err", 0);
      hold(2'b11, 8);
      pop_chk(ERR); pop_chk(POS);
      rd_pulse();
      pop_chk(RDATA); pop_chk(ERR);
      push("rdset_err", 1); push("rdset_rdata", 0); push("rd2_rdata", 8'h20); push("rd2_err", 0);
      hold(2'b00, 4);
      rd_pulse();
      pop_chk(ERR); pop_chk(RDATA);
      hold(2'b00, 4);
      rd_pulse();
      pop_chk(RDATA); pop_chk(ERR);
      // home switch overrides a completing up step at POS=7
      push("pre_ctr_pos", 7);
      for (int i = 0; i < 7; i++) up_cyc();
      pop_chk(POS);
      s0 = step_cnt;
      w0 = wrap_cnt;
      push("ctr_pos", 0); push("ctr_steps", 0); push("ctr_wraps", 0); push("ctr_du", 0);
      hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
      nCENTER = 1'b0;
      hold(2'b00, 10);
      pop_chk(POS); pop_chk(8'(step_cnt - s0)); pop_chk(8'(wrap_cnt - w0)); pop_chk(DU);
      nCENTER = 1'b1;
      push("post_ctr_pos", 1); push("post_ctr_steps", 1);
      hold(2'b00, 8);
      up_cyc();
      pop_chk(POS); pop_chk(8'(step_cnt - s0));
      // async reset between clock edges at POS=5 with ERR set
      push("pre_rst_rdata", 8'h25); push("pre_rst_pos", 5); push("pre_rst_err", 1);
      for (int i = 0; i < 4; i++) up_cyc();
      hold(2'b11, 8);
      rd_pulse();
      pop_chk(RDATA);
      hold(2'b00, 8);
      pop_chk(POS); pop_chk(ERR);
      push("ar_pos", 0); push("ar_du", 0); push("ar_step", 0);
      push("ar_wrap", 0); push("ar_err", 0); push("ar_rdata", 0);
      #3 nRESET = 1'b0;
      #1;
      pop_chk(POS); pop_chk(DU); pop_chk(STEP); pop_chk(WRAP); pop_chk(ERR); pop_chk(RDATA);
      @(negedge CLK) nRESET = 1'b1;
      @(posedge CLK);
      #1;
      push("rs_pos", 1); push("rs_du", 0); push("rs_err", 0);
      up_cyc();
      pop_chk(POS); pop_chk(DU); pop_chk(ERR);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
